uart_rx_line: RTL and testbench
===============================

Name: uart_rx_line

Overview:
Line assembler on the receive side of the UART link; it is the counterpart of the string transmitter. It consumes bytes strobed out of the UART receiver (rx_done/rx_data), stores printable bytes in a line buffer, handles CR/LF/backspace, and signals a completed line to the application. The buffer is locked until the consumer acknowledges the line, and the consumer reads it through a synchronous read port.

Parameters:
MAX_LEN, 32, line buffer capacity in bytes; must equal 2**ADDR_W
ADDR_W, 5, buffer address width
LEN_W, 6, width of length outputs (ADDR_W+1, holds 0..MAX_LEN)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_data  in  8  received byte from UART receiver
rx_done  in  1  one-cycle strobe: rx_data valid this cycle
line_ack  in  1  one-cycle strobe from consumer: line consumed, release buffer
rd_addr  in  ADDR_W  buffer read address
rd_data  out  8  buffer byte at rd_addr, 1-cycle read latency
line_len  out  LEN_W  length of completed line (valid while line_valid)
line_valid  out  1  level: completed line held in buffer
line_done  out  1  one-cycle pulse on line completion
overflow  out  1  sticky: bytes lost because the line exceeded MAX_LEN
dropped  out  1  sticky: bytes arrived while the buffer was locked

Behaviour:
- Reset values: state=COLLECT, count=0, line_len=0, line_valid=0, line_done=0, overflow=0, dropped=0, rd_data=0. Buffer contents are not reset. Reset mid-line discards the partial line.
- Constants: CR=0x0D, LF=0x0A, BS=0x08, DEL=0x7F.
- State COLLECT, on rx_done:
  - CR: ignored; no state change.
  - LF: line_len<=count, line_valid<=1, state<=HOLD. line_done is high for exactly the one cycle after the LF rx_done cycle.
  - BS or DEL: if count>0 then count<=count-1, else ignored. The overflow flag is unaffected.
  - Any other byte: if count<MAX_LEN, buf[count]<=rx_data and count<=count+1. Otherwise the byte is discarded and overflow<=1.
- LF with count=0 completes an empty line: line_len=0, line_done pulses.
- A completed overflowed line has line_len=MAX_LEN, overflow=1, and buffer contents equal to the first MAX_LEN bytes (after backspace edits).
- State HOLD:
  - rx_done bytes of any value, including LF, are discarded and dropped<=1. The buffer and line_len are unchanged.
  - line_ack: state<=COLLECT, count<=0, line_valid<=0, overflow<=0, dropped<=0. line_len holds its value until the next completion.
- line_ack in COLLECT is ignored.
- line_ack and rx_done in the same HOLD cycle: ack takes effect, and the byte is processed as the first byte of the new line with count=0. Flags are cleared and not set by that byte, except overflow/dropped, which cannot occur at count 0. An LF in that cycle therefore yields an immediate empty line, with line_done on the next cycle.
- rx_done is ignored while line_done is being generated; line_done never coincides with a second completion.
- rd_data <= buf[rd_addr] every cycle, regardless of state. Contents at addresses >= line_len are stale and unspecified. A write and a read to the same address in the same cycle return the old data.
- No arithmetic wrap: count saturates at MAX_LEN and never underflows below 0.

Decomposition:
- Shared package (uart_pkg): ASCII_CR, ASCII_LF, ASCII_BS, ASCII_DEL constants; state encoding COLLECT/HOLD.
- One sub-module, uart_line_ram: MAX_LEN x 8 single-write, synchronous-read RAM (we, waddr, wdata, raddr, rdata).
- Control FSM, count, and flags live in uart_rx_line.

Test Plan:
- Bytes 41 44 41 4D 0D 0A, each as a single-cycle rx_done -> line_done one pulse one cycle after the 0A strobe; line_valid=1, line_len=4; rd_addr 0..3 returns 41 44 41 4D one cycle later; overflow=0, dropped=0.
- 0A alone -> line_done pulse, line_len=0; line_ack -> line_valid=0; next line 58 0A -> line_len=1, rd[0]=58.
- Bytes 08, 41, 42, 08, 43, 0A -> leading BS ignored; line_len=2, rd[0..1]=41 43.
- With MAX_LEN=32: 40 bytes 30..57 then 0A -> line_len=32, overflow=1, rd[31]=4F; line_ack clears overflow.
- In HOLD: send 5A -> dropped=1, line_len and buffer unchanged. Then assert line_ack and rx_done(61) in the same cycle -> line_valid=0, dropped=0, then 0A -> line_len=1, rd[0]=61.
- Send 41 42, assert reset for one cycle, then 43 0A -> line_len=1, rd[0]=43, no line_done during reset.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: ASCII control codes and the line-assembler state encoding.
package uart_pkg;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_DEL = 8'h7F;

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_HOLD    = 1'b1;

    function automatic logic is_erase(input logic [7:0] b);
        return (b == ASCII_BS) || (b == ASCII_DEL);
    endfunction

endpackage

// File: rtl/uart_line_ram.sv
// Line buffer storage: single write port, synchronous read port (read-before-write on collision).
module uart_line_ram #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [DEPTH];

    // NOTE: the array itself has no reset so it can map onto RAM primitives; only the read register is reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata <= 8'h00;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/uart_rx_line.sv
// Receive-side line assembler: collects printable bytes, applies backspace edits,
// completes a line on LF and holds it locked until the consumer acknowledges.
module uart_rx_line
    import uart_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int ADDR_W  = 5,
    parameter int LEN_W   = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              line_ack,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic [LEN_W-1:0]  line_len,
    output logic              line_valid,
    output logic              line_done,
    output logic              overflow,
    output logic              dropped
);

    localparam logic [LEN_W-1:0] FULL = LEN_W'(MAX_LEN);

    logic [0:0]       state;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] eff_count;
    logic             byte_ev;
    logic             accept;
    logic             is_lf;
    logic             is_cr;
    logic             is_del;
    logic             is_data;
    logic             we;

    // An ack in HOLD reopens the buffer in the same cycle, so a coincident byte sees count 0.
    assign accept    = (state == ST_COLLECT) || line_ack;
    assign eff_count = (state == ST_HOLD) ? '0 : count;
    assign byte_ev   = rx_done && !line_done;

    assign is_lf   = (rx_data == ASCII_LF);
    assign is_cr   = (rx_data == ASCII_CR);
    assign is_del  = is_erase(rx_data);
    assign is_data = !is_lf && !is_cr && !is_del;

    assign we         = byte_ev && accept && is_data && (eff_count < FULL);
    assign line_valid = (state == ST_HOLD);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_COLLECT;
            count     <= '0;
            line_len  <= '0;
            line_done <= 1'b0;
            overflow  <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            line_done <= 1'b0;

            if ((state == ST_HOLD) && line_ack) begin
                state    <= ST_COLLECT;
                count    <= '0;
                overflow <= 1'b0;
                dropped  <= 1'b0;
            end

            if (byte_ev) begin
                if (!accept) begin
                    dropped <= 1'b1;
                end else if (is_lf) begin
                    line_len  <= eff_count;
                    state     <= ST_HOLD;
                    line_done <= 1'b1;
                end else if (is_del) begin
                    if (eff_count != '0) begin
                        count <= eff_count - LEN_W'(1);
                    end
                end else if (is_data) begin
                    if (eff_count < FULL) begin
                        count <= eff_count + LEN_W'(1);
                    end else begin
                        overflow <= 1'b1;
                    end
                end
            end
        end
    end

    uart_line_ram #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock (clock),
        .reset (reset),
        .we    (we),
        .waddr (eff_count[ADDR_W-1:0]),
        .wdata (rx_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_uart_rx_line.sv
// Scoreboard bench for uart_rx_line: queue-based line model, randomized lines, decoupled monitor.
module tb_uart_rx_line;

    localparam int MAX_LEN = 32;
    localparam int ADDR_W  = 5;
    localparam int LEN_W   = 6;
    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] LF  = 8'h0A;
    localparam logic [7:0] BS  = 8'h08;
    localparam logic [7:0] DEL = 8'h7F;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_done = 1'b0;
    logic              line_ack = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [7:0]        rd_data;
    logic [LEN_W-1:0]  line_len;
    logic              line_valid;
    logic              line_done;
    logic              overflow;
    logic              dropped;

    always #5 clock = ~clock;

    uart_rx_line #(.MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .line_ack   (line_ack),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .line_len   (line_len),
        .line_valid (line_valid),
        .line_done  (line_done),
        .overflow   (overflow),
        .dropped    (dropped)
    );

    typedef struct {
        int len;
        bit ovf;
    } exp_line_t;

    exp_line_t  line_q[$];
    logic [7:0] rd_exp_q[$];

    // Reference model: the line is a byte queue, the locked buffer a plain array.
    logic [7:0] m_line[$];
    logic [7:0] m_mem[MAX_LEN];
    bit         m_hold = 1'b0;
    bit         m_ovf  = 1'b0;
    bit         m_drop = 1'b0;
    int         m_len  = 0;

    int passed = 0;
    int total  = 0;
    int done_seen = 0;
    int lines_expected = 0;
    bit rd_req  = 1'b0;
    bit rd_pipe = 1'b0;
    exp_line_t mon_e;
    logic [7:0] mon_b;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_line.delete();
        m_hold = 1'b0;
        m_ovf  = 1'b0;
        m_drop = 1'b0;
        m_len  = 0;
    endtask

    task automatic model_step(input logic [7:0] b, input bit valid, input bit ack);
        if (m_hold && ack) begin
            m_hold = 1'b0;
            m_line.delete();
            m_ovf  = 1'b0;
            m_drop = 1'b0;
        end
        if (valid) begin
            if (m_hold) begin
                m_drop = 1'b1;
            end else if (b == LF) begin
                line_q.push_back('{len: m_line.size(), ovf: m_ovf});
                lines_expected++;
                for (int i = 0; i < m_line.size(); i++) m_mem[i] = m_line[i];
                m_len  = m_line.size();
                m_hold = 1'b1;
            end else if (b == BS || b == DEL) begin
                if (m_line.size() > 0) void'(m_line.pop_back());
            end else if (b != CR) begin
                if (m_line.size() < MAX_LEN) m_line.push_back(b);
                else m_ovf = 1'b1;
            end
        end
    endtask

    // Inputs change 1 time unit after the rising edge; each byte is followed by an idle cycle.
    task automatic send(input logic [7:0] b, input bit ack);
        rx_data  = b;
        rx_done  = 1'b1;
        line_ack = ack;
        model_step(b, 1'b1, ack);
        @(posedge clock); #1;
        rx_done  = 1'b0;
        line_ack = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic do_ack();
        line_ack = 1'b1;
        model_step(8'h00, 1'b0, 1'b1);
        @(posedge clock); #1;
        line_ack = 1'b0;
        check("valid_after_ack", int'(line_valid), 0);
        check("overflow_after_ack", int'(overflow), int'(m_ovf));
        check("dropped_after_ack", int'(dropped), int'(m_drop));
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!line_valid && k < 8) begin
            @(posedge clock); #1;
            k++;
        end
        check("line_valid_after_lf", int'(line_valid), 1);
    endtask

    task automatic read_back(input int n);
        for (int i = 0; i < n; i++) begin
            rd_addr = ADDR_W'(i);
            rd_exp_q.push_back(m_mem[i]);
            rd_req = 1'b1;
            @(posedge clock); #1;
        end
        rd_req = 1'b0;
        @(posedge clock); #1;
    endtask

    function automatic logic [7:0] rand_byte();
        int r = $urandom_range(0, 9);
        if (r == 0) return ($urandom_range(0, 1) == 1) ? BS : DEL;
        if (r == 1) return CR;
        return 8'($urandom_range(8'h20, 8'h7E));
    endfunction

    always @(posedge clock) rd_pipe <= rd_req;

    always @(negedge clock) begin
        if (rd_pipe) begin
            if (rd_exp_q.size() == 0) begin
                check("rd_unexpected", 1, 0);
            end else begin
                mon_b = rd_exp_q.pop_front();
                check("rd_data", int'(rd_data), int'(mon_b));
            end
        end
        if (line_done) begin
            done_seen++;
            if (line_q.size() == 0) begin
                check("line_done_unexpected", 1, 0);
            end else begin
                mon_e = line_q.pop_front();
                check("line_len", int'(line_len), mon_e.len);
                check("overflow_at_done", int'(overflow), int'(mon_e.ovf));
                check("line_valid_at_done", int'(line_valid), 1);
                check("dropped_at_done", int'(dropped), 0);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq1[$];

        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_line_done", int'(line_done), 0);
        check("rst_line_valid", int'(line_valid), 0);
        check("rst_line_len", int'(line_len), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_dropped", int'(dropped), 0);
        check("rst_rd_data", int'(rd_data), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();

        // Basic line with a CR before the LF.
        seq1 = '{8'h41, 8'h44, 8'h41, 8'h4D, CR, LF};
        foreach (seq1[i]) send(seq1[i], 1'b0);
        wait_valid();
        read_back(m_len);
        do_ack();

        // Empty line, then a one-byte line.
        send(LF, 1'b0);
        wait_valid();
        do_ack();
        send(8'h58, 1'b0);
        send(LF, 1'b0);
        wait_valid();
        read_back(m_len);
        do_ack();

        // Leading backspace ignored, inner backspace erases.
        seq1 = '{BS, 8'h41, 8'h42, BS, 8'h43, LF};
        foreach (seq1[i]) send(seq1[i], 1'b0);
        wait_valid();
        read_back(m_len);
        do_ack();

        // Overflow: 40 bytes into a 32-byte buffer.
        for (int i = 0; i < 40; i++) send(8'(8'h30 + i), 1'b0);
        send(LF, 1'b0);
        wait_valid();
        check("ovf_flag", int'(overflow), 1);
        read_back(m_len);
        do_ack();

        // Byte while locked is dropped; ack with a coincident byte starts the next line.
        send(8'h41, 1'b0);
        send(8'h42, 1'b0);
        send(LF, 1'b0);
        wait_valid();
        send(8'h5A, 1'b0);
        check("hold_dropped", int'(dropped), 1);
        check("hold_len", int'(line_len), m_len);
        check("hold_valid", int'(line_valid), 1);
        read_back(m_len);
        send(8'h61, 1'b1);
        check("ackbyte_valid", int'(line_valid), 0);
        check("ackbyte_dropped", int'(dropped), 0);
        send(LF, 1'b0);
        wait_valid();
        read_back(m_len);
        do_ack();

        // Reset mid-line discards the partial line.
        send(8'h41, 1'b0);
        send(8'h42, 1'b0);
        reset = 1'b1;
        model_reset();
        @(posedge clock); #1;
        reset = 1'b0;
        check("midrst_len", int'(line_len), 0);
        check("midrst_valid", int'(line_valid), 0);
        send(8'h43, 1'b0);
        send(LF, 1'b0);
        wait_valid();
        read_back(m_len);
        do_ack();

        // Randomized lines with random hold-time traffic and ack styles.
        for (int it = 0; it < 40; it++) begin
            int n = $urandom_range(0, 44);
            for (int j = 0; j < n; j++) send(rand_byte(), 1'b0);
            send(LF, 1'b0);
            while (m_hold) begin
                wait_valid();
                check("rand_len", int'(line_len), m_len);
                read_back(m_len);
                if ($urandom_range(0, 2) == 0) begin
                    send(($urandom_range(0, 1) == 1) ? LF : rand_byte(), 1'b0);
                    check("rand_dropped", int'(dropped), int'(m_drop));
                end
                if ($urandom_range(0, 1) == 1) begin
                    send(($urandom_range(0, 3) == 0) ? LF : rand_byte(), 1'b1);
                    check("rand_ackbyte_dropped", int'(dropped), int'(m_drop));
                    check("rand_ackbyte_valid", int'(line_valid), int'(m_hold));
                end else begin
                    do_ack();
                end
            end
        end

        repeat (3) @(posedge clock);
        #1;
        check("lines_pending", line_q.size(), 0);
        check("reads_pending", rd_exp_q.size(), 0);
        check("done_count", done_seen, lines_expected);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
